// File: rtl/demux14_2bit_buf.sv
// Key-routed 1-to-NR_CH demultiplexer with a DEPTH-entry first-word-fall-through
// FIFO per output channel; out-of-range keys are accepted and counted as drops.
module demux14_2bit_buf #(
  parameter int NR_CH    = 4,
  parameter int KEY_LEN  = 2,
  parameter int DATA_LEN = 2,
  parameter int DEPTH    = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [KEY_LEN-1:0]        in_key,
  input  logic [DATA_LEN-1:0]       in_data,
  output logic [NR_CH-1:0]          out_valid,
  input  logic [NR_CH-1:0]          out_ready,
  output logic [NR_CH*DATA_LEN-1:0] out_data,
  output logic [7:0]                drop_cnt
);

  localparam int               PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int               CNT_W   = $clog2(DEPTH + 1);
  localparam logic [KEY_LEN:0] NR_CH_K = (KEY_LEN + 1)'(NR_CH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic             key_ok;
  logic             sel_full;
  logic             accept;
  logic [NR_CH-1:0] full;
  logic [NR_CH-1:0] push;
  logic [NR_CH-1:0] pop;

  // in_ready looks only at the addressed channel's fill level, never at out_ready
  always_comb begin
    key_ok   = {1'b0, in_key} < NR_CH_K;
    sel_full = 1'b0;
    for (int c = 0; c < NR_CH; c++) begin
      if (in_key == KEY_LEN'(c)) sel_full = full[c];
    end
    in_ready = key_ok ? ~sel_full : 1'b1;
    accept   = in_valid & in_ready;
  end

  for (genvar c = 0; c < NR_CH; c++) begin : g_ch
    logic [DATA_LEN-1:0] mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    cnt;

    assign full[c]      = (cnt == DEPTH_C);
    assign out_valid[c] = (cnt != '0);
    assign push[c]      = accept & (in_key == KEY_LEN'(c));
    assign pop[c]       = out_valid[c] & out_ready[c];
    assign out_data[DATA_LEN*(c+1)-1 -: DATA_LEN] = out_valid[c] ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
      end else begin
        if (push[c]) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop[c])  rd_ptr <= rd_ptr + PTR_W'(1);
        case ({push[c], pop[c]})
          2'b10:   cnt <= cnt + CNT_W'(1);
          2'b01:   cnt <= cnt - CNT_W'(1);
          default: cnt <= cnt;
        endcase
      end
    end

    // Storage is not reset; out_data masking hides stale entries
    always_ff @(posedge clk) begin
      if (push[c]) mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  drop_cnt <= '0;
    else if (in_valid & ~key_ok) drop_cnt <= sat_inc8(drop_cnt);
  end

endmodule

// File: tb/tb_demux14_2bit_buf.sv
// Directed bench for demux14_2bit_buf: a 4-channel instance for routing/FIFO
// behaviour and a 3-channel instance for out-of-range key drops.
module tb_demux14_2bit_buf;

  logic       clk = 1'b0;
  logic       rst_n;
  // 4-channel instance
  logic       in_valid, in_ready;
  logic [1:0] in_key, in_data;
  logic [3:0] out_valid, out_ready;
  logic [7:0] out_data, drop_cnt;
  // 3-channel instance
  logic       in_valid3, in_ready3;
  logic [1:0] in_key3, in_data3;
  logic [2:0] out_valid3, out_ready3;
  logic [5:0] out_data3;
  logic [7:0] drop_cnt3;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  demux14_2bit_buf #(.NR_CH(4), .KEY_LEN(2), .DATA_LEN(2), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_key(in_key), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .drop_cnt(drop_cnt));

  demux14_2bit_buf #(.NR_CH(3), .KEY_LEN(2), .DATA_LEN(2), .DEPTH(2)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .in_ready(in_ready3),
    .in_key(in_key3), .in_data(in_data3), .out_valid(out_valid3),
    .out_ready(out_ready3), .out_data(out_data3), .drop_cnt(drop_cnt3));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] q[$];
  logic [1:0] vals[6];
  int         sent, popped;
  logic       do_push, do_pop;

  initial begin
    rst_n = 1'b0;
    in_valid = 0; in_key = 0; in_data = 0; out_ready = 0;
    in_valid3 = 0; in_key3 = 0; in_data3 = 0; out_ready3 = 0;
    #1;
    chk("rst_out_valid", out_valid, 4'b0000);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_drop", drop_cnt3, 8'd0);
    step();
    rst_n = 1'b1;
    step();

    // 1: ch1 holds two words, dut3 has some drops, then async reset mid-cycle
    in_valid = 1; in_key = 2'd1; in_data = 2'd2;
    in_valid3 = 1; in_key3 = 2'd3;
    step();
    in_data = 2'd3;
    step();
    in_valid = 0; in_valid3 = 0;
    chk("t1_ch1_loaded", out_valid, 4'b0010);
    chk("t1_drops_before", drop_cnt3, 8'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_async_valid", out_valid, 4'b0000);
    chk("t1_async_data", out_data, 8'h00);
    chk("t1_async_drop", drop_cnt3, 8'd0);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_key = 2'(k);
      #0.5;
      chk($sformatf("t1_ready_key%0d", k), in_ready, 1'b1);
    end
    step();

    // 2: route one word to each channel
    for (int k = 0; k < 4; k++) begin
      in_valid = 1; in_key = 2'(k); in_data = 2'(3 - k);
      step();
      chk($sformatf("t2_valid_after_key%0d", k), out_valid[k], 1'b1);
    end
    in_valid = 0;
    chk("t2_all_valid", out_valid, 4'b1111);
    chk("t2_all_data", out_data, 8'b00_01_10_11);
    out_ready = 4'b1111;
    step();
    out_ready = 4'b0000;
    chk("t2_drained", out_valid, 4'b0000);

    // 3: fill ch2, no pass-through while full
    in_valid = 1; in_key = 2'd2; in_data = 2'd1;
    step();
    in_data = 2'd2;
    step();
    in_data = 2'd3;
    #1;
    chk("t3_full_blocks", in_ready, 1'b0);
    out_ready[2] = 1'b1;
    #1;
    chk("t3_full_ignores_rdy", in_ready, 1'b0);
    chk("t3_head_first", out_data[5:4], 2'd1);
    step();
    out_ready[2] = 1'b0;
    chk("t3_ready_after_pop", in_ready, 1'b1);
    chk("t3_head_second", out_data[5:4], 2'd2);
    step();
    in_valid = 0;
    #1;
    chk("t3_full_again", in_ready, 1'b0);
    out_ready[2] = 1'b1;
    step();
    chk("t3_drain_third", out_data[5:4], 2'd3);
    step();
    out_ready[2] = 1'b0;
    chk("t3_empty", out_valid[2], 1'b0);

    // 4: six words through ch0 with toggling out_ready, checked against a queue
    vals = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    sent = 0; popped = 0;
    q.delete();
    in_key = 2'd0;
    for (int cyc = 0; cyc < 40 && popped < 6; cyc++) begin
      in_valid = (sent < 6);
      in_data  = (sent < 6) ? vals[sent] : 2'd0;
      out_ready[0] = cyc[0];
      #1;
      chk("t4_valid", out_valid[0], q.size() != 0);
      chk("t4_ready", in_ready, q.size() < 2);
      if (q.size() != 0) chk("t4_head", out_data[1:0], q[0]);
      do_push = in_valid && (q.size() < 2);
      do_pop  = out_ready[0] && (q.size() != 0);
      step();
      if (do_pop) begin
        void'(q.pop_front());
        popped++;
      end
      if (do_push) begin
        q.push_back(vals[sent]);
        sent++;
      end
    end
    in_valid = 0; out_ready = 4'b0000;
    chk("t4_all_popped", popped, 6);
    chk("t4_empty", out_valid[0], 1'b0);

    // 5: out-of-range key on 3-channel instance, drop counter saturates
    in_valid3 = 1; in_key3 = 2'd3; in_data3 = 2'd1;
    #1;
    chk("t5_ready", in_ready3, 1'b1);
    for (int i = 0; i < 300; i++) begin
      step();
      if (i == 253) chk("t5_cnt_254", drop_cnt3, 8'd254);
      if (i == 254) chk("t5_cnt_255", drop_cnt3, 8'd255);
    end
    in_valid3 = 0;
    chk("t5_saturated", drop_cnt3, 8'd255);
    chk("t5_no_valid", out_valid3, 3'b000);
    chk("t5_ready_end", in_ready3, 1'b1);

    // 6: push and pop ch1 on the same edge
    in_valid = 1; in_key = 2'd1; in_data = 2'd2;
    step();
    in_data = 2'd1; out_ready[1] = 1'b1;
    #1;
    chk("t6_old_head", out_data[3:2], 2'd2);
    step();
    in_valid = 0;
    chk("t6_still_valid", out_valid[1], 1'b1);
    chk("t6_new_head", out_data[3:2], 2'd1);
    step();
    out_ready[1] = 1'b0;
    chk("t6_count_was_one", out_valid[1], 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
